// File: rtl/tm1637_serializer_if.sv
// Byte-stream handshake between the LED_TM1637 step sequencer and the TM1637 serializer.
// Valid/ready rule: a byte moves on any clk edge where in_valid & in_ready are both high;
// in_ready never depends on in_valid, and stop_req is a single-cycle request with no handshake.
interface tm1637_serializer_if;
    logic [7:0] in_data;
    logic       in_stop;
    logic       in_valid;
    logic       in_ready;
    logic       stop_req;

    modport master (
        output in_data,
        output in_stop,
        output in_valid,
        output stop_req,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_stop,
        input  in_valid,
        input  stop_req,
        output in_ready
    );
endinterface

// File: rtl/tm1637_serializer.sv
// TM1637 two-wire byte transmitter: START, 8 bits LSB first, ACK clock, optional STOP.
// The frame stays open in HOLD between bytes so consecutive bytes share a single START.
module tm1637_serializer #(
    parameter int HALF_PERIOD = 100,
    parameter int CNT_W       = $clog2(HALF_PERIOD)
) (
    input  logic                      clk,
    input  logic                      rst,
    tm1637_serializer_if.slave        bus,
    output logic                      tm1637_clk,
    output logic                      tm1637_dio_o,
    output logic                      tm1637_dio_oe,
    input  logic                      tm1637_dio_i,
    output logic                      byte_done,
    output logic                      ack_ok,
    output logic                      busy,
    output logic [3:0]                dbg_state
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_START_A = 4'd1;
    localparam logic [3:0] ST_START_B = 4'd2;
    localparam logic [3:0] ST_BIT_LO  = 4'd3;
    localparam logic [3:0] ST_BIT_HI  = 4'd4;
    localparam logic [3:0] ST_ACK_LO  = 4'd5;
    localparam logic [3:0] ST_ACK_HI  = 4'd6;
    localparam logic [3:0] ST_HOLD    = 4'd7;
    localparam logic [3:0] ST_STOP_A  = 4'd8;
    localparam logic [3:0] ST_STOP_B  = 4'd9;
    localparam logic [3:0] ST_STOP_C  = 4'd10;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(HALF_PERIOD - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             stop_q, stop_d;
    logic             ack_ok_q, ack_ok_d;
    logic             clk_q, clk_d;
    logic             dio_q, dio_d;
    logic             oe_q, oe_d;

    logic phase_end;
    logic accept;
    logic waiting;

    assign waiting   = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign phase_end = (timer_q == TIMER_LAST);
    assign accept    = bus.in_valid && waiting;

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        stop_d   = stop_q;
        ack_ok_d = ack_ok_q;
        // IDLE/HOLD wait without timing; every other state is one half period long.
        timer_d  = (waiting || phase_end) ? '0 : timer_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = bus.in_data;
                    stop_d  = bus.in_stop;
                    state_d = ST_START_A;
                end
            end
            ST_START_A: if (phase_end) state_d = ST_START_B;
            ST_START_B: begin
                if (phase_end) begin
                    bit_d   = 3'd0;
                    state_d = ST_BIT_LO;
                end
            end
            ST_BIT_LO: if (phase_end) state_d = ST_BIT_HI;
            ST_BIT_HI: begin
                if (phase_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_ACK_LO;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = ST_BIT_LO;
                    end
                end
            end
            ST_ACK_LO: if (phase_end) state_d = ST_ACK_HI;
            ST_ACK_HI: begin
                if (phase_end) begin
                    ack_ok_d = ~tm1637_dio_i;
                    state_d  = stop_q ? ST_STOP_A : ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A new byte wins over a simultaneous close request.
                if (accept) begin
                    shift_d = bus.in_data;
                    stop_d  = bus.in_stop;
                    bit_d   = 3'd0;
                    state_d = ST_BIT_LO;
                end else if (bus.stop_req) begin
                    state_d = ST_STOP_A;
                end
            end
            ST_STOP_A: if (phase_end) state_d = ST_STOP_B;
            ST_STOP_B: if (phase_end) state_d = ST_STOP_C;
            ST_STOP_C: if (phase_end) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pins are decoded from the next state so they change on the first cycle of each phase.
    always_comb begin
        clk_d = 1'b1;
        dio_d = 1'b1;
        oe_d  = 1'b1;
        case (state_d)
            ST_START_A: dio_d = 1'b0;
            ST_START_B: begin clk_d = 1'b0; dio_d = 1'b0; end
            ST_BIT_LO:  begin clk_d = 1'b0; dio_d = shift_d[0]; end
            ST_BIT_HI:  dio_d = shift_d[0];
            ST_ACK_LO:  begin clk_d = 1'b0; oe_d = 1'b0; end
            ST_ACK_HI:  oe_d = 1'b0;
            ST_HOLD:    begin clk_d = 1'b0; dio_d = 1'b0; end
            ST_STOP_A:  begin clk_d = 1'b0; dio_d = 1'b0; end
            ST_STOP_B:  dio_d = 1'b0;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            stop_q   <= 1'b0;
            ack_ok_q <= 1'b0;
            clk_q    <= 1'b1;
            dio_q    <= 1'b1;
            oe_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            stop_q   <= stop_d;
            ack_ok_q <= ack_ok_d;
            clk_q    <= clk_d;
            dio_q    <= dio_d;
            oe_q     <= oe_d;
        end
    end

    assign bus.in_ready  = waiting;
    assign busy          = (state_q != ST_IDLE);
    assign byte_done     = (state_q == ST_ACK_HI) && phase_end;
    // During the sample cycle the fresh ACK is shown; afterwards the held copy.
    assign ack_ok        = byte_done ? ~tm1637_dio_i : ack_ok_q;
    assign tm1637_clk    = clk_q;
    assign tm1637_dio_o  = dio_q;
    assign tm1637_dio_oe = oe_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_tm1637_serializer.sv
// Directed bench for tm1637_serializer: a driver pushes expected bytes into a queue and a
// negedge monitor decodes the pins, popping and comparing at every byte_done.
module tb_tm1637_serializer;
  localparam int H = 4;
  localparam int W = 25;  // {done_cycle[15:0], ack, data[7:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tm1637_serializer_if bus();
  logic       tclk, dio_o, dio_oe, dio_i, byte_done, ack_ok, busy;
  logic [3:0] dbg_state;

  tm1637_serializer #(.HALF_PERIOD(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .tm1637_clk    (tclk),
    .tm1637_dio_o  (dio_o),
    .tm1637_dio_oe (dio_oe),
    .tm1637_dio_i  (dio_i),
    .byte_done     (byte_done),
    .ack_ok        (ack_ok),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int starts = 0, stops = 0, done_cnt = 0, ready_viol = 0;
  int exp_starts = 0, exp_stops = 0, exp_done = 0;
  logic mon_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       p_clk = 1'b1, p_dio = 1'b1, p_oe = 1'b1;
  logic [7:0] col = 8'h00;
  int         nbits = 0, oe_low = 0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst || mon_hold) begin
      nbits = 0;
      oe_low = 0;
    end else begin
      if (!dio_oe) oe_low++;
      if (tclk && !p_clk && dio_oe) begin
        if (nbits < 8) col[nbits] = dio_o;
        nbits++;
      end
      if (tclk && p_clk && dio_oe && p_oe && p_dio && !dio_o) begin
        starts++;
        nbits = 0;
      end
      if (tclk && p_clk && dio_oe && p_oe && !p_dio && dio_o) begin
        stops++;
        nbits = 0;
      end
      if (bus.in_ready && !((tclk && dio_o && dio_oe && !busy) || (!tclk && !dio_o && dio_oe && busy)))
        ready_viol++;
      if (!bus.in_ready && !busy) ready_viol++;
      if (byte_done) begin
        done_cnt++;
        check("byte_done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(16'(cyc)), 32'(e[24:9]));
          check("ack_ok", 32'(ack_ok), 32'(e[8]));
          check("data_bits", 32'(col), 32'(e[7:0]));
          check("bit_clocks", 32'(nbits), 32'd8);
          check("ack_release_cycles", 32'(oe_low), 32'(2 * H));
        end
        nbits = 0;
        oe_low = 0;
      end
    end
    p_clk = tclk;
    p_dio = dio_o;
    p_oe  = dio_oe;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] d, input logic s, input logic from_hold,
                      input logic sreq, output int acc);
    int n;
    @(negedge clk);
    bus.in_data = d;
    bus.in_stop = s;
    bus.in_valid = 1'b1;
    bus.stop_req = sreq;
    n = 0;
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 500), 32'd1);
    acc = cyc;
    exp_q.push_back({16'(acc + (from_hold ? 18 : 20) * H), ~dio_i, d});
    if (!from_hold) exp_starts++;
    if (s) exp_stops++;
    exp_done++;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.stop_req = 1'b0;
    bus.in_data = 8'($urandom_range(0, 255));
    bus.in_stop = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    bus.stop_req = 1'b1;
    @(posedge clk);
    #1;
    bus.stop_req = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("byte_done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    bus.in_data = 8'h00;
    bus.in_stop = 1'b0;
    bus.in_valid = 1'b0;
    bus.stop_req = 1'b0;
    dio_i = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_clk", 32'(tclk), 32'd1);
    check("rst_dio", 32'(dio_o), 32'd1);
    check("rst_oe", 32'(dio_oe), 32'd1);
    check("rst_byte_done", 32'(byte_done), 32'd0);
    check("rst_ack_ok", 32'(ack_ok), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0x8F with STOP, ACK low
    send(8'h8F, 1'b1, 1'b0, 1'b0, acc);
    wait_until(acc + 80);
    check("s1_busy_at_done", 32'(busy), 32'd1);
    wait_until(acc + 91);
    check("s1_stop_c_busy", 32'(busy), 32'd1);
    check("s1_stop_c_dio", 32'(dio_o), 32'd1);
    wait_until(acc + 93);
    check("s1_idle", 32'(busy), 32'd0);
    check("s1_done_cnt", 32'(done_cnt), 32'(exp_done));
    check("s1_starts", 32'(starts), 32'(exp_starts));
    check("s1_stops", 32'(stops), 32'(exp_stops));

    // two bytes sharing one frame
    send(8'h40, 1'b0, 1'b0, 1'b0, acc);
    wait_done(exp_done);
    repeat (20) @(negedge clk);
    check("s2_hold_clk", 32'(tclk), 32'd0);
    check("s2_hold_dio", 32'(dio_o), 32'd0);
    check("s2_hold_oe", 32'(dio_oe), 32'd1);
    check("s2_hold_busy", 32'(busy), 32'd1);
    check("s2_hold_ready", 32'(bus.in_ready), 32'd1);
    send(8'hC0, 1'b1, 1'b1, 1'b0, acc);
    wait_done(exp_done);
    wait_idle();
    check("s2_starts", 32'(starts), 32'(exp_starts));
    check("s2_stops", 32'(stops), 32'(exp_stops));

    // NAK: no retry, STOP still issued
    dio_i = 1'b1;
    send(8'h5A, 1'b1, 1'b0, 1'b0, acc);
    wait_done(exp_done);
    wait_idle();
    repeat (100) @(negedge clk);
    check("s3_no_retry", 32'(done_cnt), 32'(exp_done));
    check("s3_idle", 32'(busy), 32'd0);
    check("s3_ack_held", 32'(ack_ok), 32'd0);
    check("s3_stops", 32'(stops), 32'(exp_stops));
    dio_i = 1'b0;

    // valid beats stop_req in HOLD; then stop_req alone closes the frame
    send(8'h12, 1'b0, 1'b0, 1'b0, acc);
    wait_done(exp_done);
    send(8'h34, 1'b0, 1'b1, 1'b1, acc);
    wait_done(exp_done);
    repeat (10) @(negedge clk);
    check("s4_still_hold", 32'(busy), 32'd1);
    check("s4_no_stop", 32'(stops), 32'(exp_stops));
    pulse_stop();
    exp_stops++;
    wait_idle();
    check("s4_stop_req", 32'(stops), 32'(exp_stops));
    pulse_stop();
    repeat (10) @(negedge clk);
    check("s4_idle_stop_ignored", 32'(busy), 32'd0);
    check("s4_idle_starts", 32'(starts), 32'(exp_starts));
    check("s4_idle_stops", 32'(stops), 32'(exp_stops));
    send(8'h77, 1'b0, 1'b0, 1'b0, acc);
    wait_until(acc + 14);
    check("s4_in_bit_hi", 32'(tclk), 32'd1);
    pulse_stop();
    wait_done(exp_done);
    repeat (5) @(negedge clk);
    check("s4_bit_hi_stop_ignored", 32'(busy), 32'd1);
    check("s4_bit_hi_stops", 32'(stops), 32'(exp_stops));
    pulse_stop();
    exp_stops++;
    wait_idle();
    check("s4_close", 32'(stops), 32'(exp_stops));

    // reset during BIT_HI of bit 3
    send(8'h08, 1'b1, 1'b0, 1'b0, acc);
    wait_until(acc + 36);
    mon_hold = 1'b1;
    wait_until(acc + 38);
    check("s5_bit3_hi", 32'(tclk), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_done--;
    exp_stops--;
    check("s5_clk", 32'(tclk), 32'd1);
    check("s5_dio", 32'(dio_o), 32'd1);
    check("s5_oe", 32'(dio_oe), 32'd1);
    check("s5_ready", 32'(bus.in_ready), 32'd1);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_byte_done", 32'(byte_done), 32'd0);
    repeat (3) @(negedge clk);
    mon_hold = 1'b0;
    repeat (100) @(negedge clk);
    check("s5_no_done", 32'(done_cnt), 32'(exp_done));
    send(8'h3C, 1'b1, 1'b0, 1'b0, acc);
    wait_done(exp_done);
    wait_idle();
    check("s5_starts", 32'(starts), 32'(exp_starts));
    check("s5_stops", 32'(stops), 32'(exp_stops));

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("ready_violations", 32'(ready_viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
